// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: memory-stage request controller for a variable-latency data memory.
// Converts EX/MEM load/store requests into a start/done handshake, stalls the
// pipeline while an access is outstanding, flags misaligned, illegal and timed-out
// accesses (sticky err), latches halt (sticky halt_out) and returns load data.
// Optional feature: define DMEM_RDBUF_EN for a one-entry read buffer that turns a
// repeated load of the last loaded address into a single-cycle, stall-free load.
module dmem_req_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [15:0] memAddr,
   input  logic [15:0] writeData,
   input  logic        HaltIn,
   output logic        mem_start,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_done,
   input  logic [15:0] mem_rdata,
   output logic        stall,
   output logic [15:0] readData,
   output logic        halt_out,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] waitCnt;
   logic             wrReg;
   logic [15:0]      addrReg;
   logic [15:0]      wdataReg;

   logic req;
   logic illegal;
   logic misaligned;
   logic bufHit;
   logic bufLoad;
   logic startNow;

   assign req        = (MemRead | MemWrite) & ~err & ~halt_out;
   assign illegal    = MemRead & MemWrite;
   assign misaligned = memAddr[0];

`ifdef DMEM_RDBUF_EN
   logic        bufValid;
   logic [15:0] bufAddr;
   logic [15:0] bufData;

   assign bufHit = bufValid & MemRead & (bufAddr == memAddr);
`else
   assign bufHit = 1'b0;
`endif

   // A buffered load completes in IDLE without touching the memory.
   assign bufLoad = (state == IDLE) & req & ~misaligned & ~illegal & bufHit;

   // NOTE: start is gated by rst so an asserted reset silences the combinational
   // handshake at once, even while a request is still held on the inputs.
   assign startNow = ~rst & (state == IDLE) & req & ~misaligned & ~illegal & ~bufHit;

   // The start cycle presents the live request; WAIT presents the latched copy.
   assign mem_start = startNow;
   assign mem_wr    = startNow ? MemWrite  : wrReg;
   assign mem_addr  = startNow ? memAddr   : addrReg;
   assign mem_wdata = startNow ? writeData : wdataReg;
   assign stall     = startNow | (state == WAIT);

   // Request FSM: issue, wait for done or timeout, release the pipeline for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         waitCnt  <= '0;
         wrReg    <= 1'b0;
         addrReg  <= 16'h0000;
         wdataReg <= 16'h0000;
         readData <= 16'h0000;
         halt_out <= 1'b0;
         err      <= 1'b0;
      end else begin
         // NOTE: all state here uses non-blocking assignments so every register
         // sees the pre-edge values of the others, independent of statement order.
         unique case (state)
            IDLE: begin
               if (startNow) begin
                  state    <= WAIT;
                  waitCnt  <= '0;
                  wrReg    <= MemWrite;
                  addrReg  <= memAddr;
                  wdataReg <= writeData;
               end else if (req && (misaligned || illegal)) begin
                  err <= 1'b1;
               end else if (!req && HaltIn) begin
                  halt_out <= 1'b1;
               end
`ifdef DMEM_RDBUF_EN
               if (bufLoad) readData <= bufData;
`endif
            end
            WAIT: begin
               if (mem_done) begin
                  if (!wrReg) readData <= mem_rdata;
                  state <= RESP;
               end else if (waitCnt == LAST_WAIT) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else if (waitCnt != '1) begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            RESP: begin
               if (HaltIn) halt_out <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_RDBUF_EN
   // Read buffer: filled by each completed load, invalidated by a store to its address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bufValid <= 1'b0;
         bufAddr  <= 16'h0000;
         bufData  <= 16'h0000;
      end else if (state == WAIT && mem_done && !wrReg) begin
         bufValid <= 1'b1;
         bufAddr  <= addrReg;
         bufData  <= mem_rdata;
      end else if (startNow && MemWrite && memAddr == bufAddr) begin
         bufValid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Testbench for dmem_req_ctrl: directed loads/stores against a scripted memory.
// Expected memory requests and stall lengths go into queues; a monitor pops and
// compares them whenever the DUT starts an access or releases a stall.
module tb_dmem_req_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead, MemWrite, HaltIn, mem_done;
   logic [15:0] memAddr, writeData, mem_rdata;
   logic        mem_start, mem_wr, stall, halt_out, err;
   logic [15:0] mem_addr, mem_wdata, readData;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } req_t;

   req_t expReq[$];
   int   expStall[$];

   int   stallCnt = 0;
   bit   inAccess = 1'b0;
   req_t cur;

   dmem_req_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .memAddr   (memAddr),
      .writeData (writeData),
      .HaltIn    (HaltIn),
      .mem_start (mem_start),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_done  (mem_done),
      .mem_rdata (mem_rdata),
      .stall     (stall),
      .readData  (readData),
      .halt_out  (halt_out),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare each started access and each completed stall window.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            stallCnt = 0;
            inAccess = 1'b0;
         end else begin
            if (mem_start) begin
               if (expReq.size() == 0) begin
                  check("unexpected_mem_start", 16'(mem_start), 16'h0);
               end else begin
                  cur      = expReq.pop_front();
                  inAccess = 1'b1;
                  check("start_addr", mem_addr, cur.addr);
                  check("start_wr", 16'(mem_wr), 16'(cur.wr));
                  if (cur.wr) check("start_wdata", mem_wdata, cur.wdata);
               end
            end else if (stall && inAccess) begin
               check("hold_start_low", 16'(mem_start), 16'h0);
               check("hold_addr", mem_addr, cur.addr);
               check("hold_wr", 16'(mem_wr), 16'(cur.wr));
               if (cur.wr) check("hold_wdata", mem_wdata, cur.wdata);
            end
            if (stall) begin
               stallCnt++;
            end else if (stallCnt > 0) begin
               if (expStall.size() == 0) check("unexpected_stall", 16'(stallCnt), 16'h0);
               else check("stall_cycles", 16'(stallCnt), 16'(expStall.pop_front()));
               stallCnt = 0;
               inAccess = 1'b0;
            end
         end
      end
   end

   // Drive one request; doneAt = WAIT cycle carrying mem_done (0 = never).
   task automatic access(input logic isWr, input logic [15:0] addr, input logic [15:0] wdata,
                         input int doneAt, input logic [15:0] rdata,
                         input bit expectStart, input bit haltResp);
      req_t r;
      MemRead   = ~isWr;
      MemWrite  = isWr;
      memAddr   = addr;
      writeData = wdata;
      if (expectStart) begin
         r.wr = isWr; r.addr = addr; r.wdata = wdata;
         expReq.push_back(r);
         expStall.push_back(doneAt > 0 ? doneAt + 1 : TIMEOUT + 1);
         @(posedge clk); #1;
         for (int i = 1; i <= TIMEOUT; i++) begin
            mem_done  = (i == doneAt);
            mem_rdata = rdata;
            @(posedge clk); #1;
            mem_done = 1'b0;
            if (i == doneAt) break;
         end
         if (doneAt > 0) begin
            HaltIn = haltResp;
            @(posedge clk); #1;
            HaltIn = 1'b0;
         end
      end else begin
         @(negedge clk);
         check("nostart_mem_start", 16'(mem_start), 16'h0);
         check("nostart_stall", 16'(stall), 16'h0);
         @(posedge clk); #1;
      end
      MemRead  = 1'b0;
      MemWrite = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Watchdog so a broken DUT can never hang the run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; HaltIn = 1'b0; mem_done = 1'b0;
      memAddr = 16'h0; writeData = 16'h0; mem_rdata = 16'h0;
      repeat (2) @(posedge clk); #1;
      check("rst_mem_start", 16'(mem_start), 16'h0);
      check("rst_stall", 16'(stall), 16'h0);
      check("rst_err", 16'(err), 16'h0);
      check("rst_halt", 16'(halt_out), 16'h0);
      check("rst_readData", readData, 16'h0000);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_mem_wdata", mem_wdata, 16'h0000);
      check("rst_mem_wr", 16'(mem_wr), 16'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Load, done 3 cycles after start: 4 stall cycles.
      access(1'b0, 16'h0010, 16'h0, 3, 16'hBEEF, 1'b1, 1'b0);
      check("load1_readData", readData, 16'hBEEF);
      check("load1_err", 16'(err), 16'h0);

      // Store leaves readData untouched.
      access(1'b1, 16'h0020, 16'h1234, 2, 16'hDEAD, 1'b1, 1'b0);
      check("store_readData", readData, 16'hBEEF);
      check("store_err", 16'(err), 16'h0);

      // Shortest access: done in the first WAIT cycle.
      access(1'b0, 16'h0030, 16'h0, 1, 16'h5A5A, 1'b1, 1'b0);
      check("load_n1_readData", readData, 16'h5A5A);

      // Done in the final WAIT cycle wins over timeout.
      access(1'b0, 16'h0050, 16'h0, TIMEOUT, 16'hABCD, 1'b1, 1'b0);
      check("load_last_readData", readData, 16'hABCD);
      check("load_last_err", 16'(err), 16'h0);

      // Reset in the middle of WAIT.
      begin
         req_t r;
         r.wr = 1'b0; r.addr = 16'h0060; r.wdata = 16'h0;
         expReq.push_back(r);
         MemRead = 1'b1; memAddr = 16'h0060;
         @(posedge clk); #1;
         @(posedge clk); #2;
         rst = 1'b1;
         #1;
         check("midrst_stall", 16'(stall), 16'h0);
         check("midrst_mem_start", 16'(mem_start), 16'h0);
         check("midrst_readData", readData, 16'h0000);
         check("midrst_mem_addr", mem_addr, 16'h0000);
         check("midrst_mem_wr", 16'(mem_wr), 16'h0);
         check("midrst_err", 16'(err), 16'h0);
         MemRead = 1'b0;
         @(posedge clk); #1;
         rst = 1'b0;
         @(posedge clk); #1;
      end
      access(1'b0, 16'h0070, 16'h0, 2, 16'h1111, 1'b1, 1'b0);
      check("post_rst_readData", readData, 16'h1111);

      // mem_done outside WAIT is ignored.
      mem_done = 1'b1; mem_rdata = 16'hFFFF;
      @(posedge clk); #1;
      mem_done = 1'b0;
      check("stray_done_readData", readData, 16'h1111);

      // Timeout: 16 WAIT cycles, then err and stall released.
      access(1'b0, 16'h0080, 16'h0, 0, 16'h0, 1'b1, 1'b0);
      check("timeout_err", 16'(err), 16'h1);
      check("timeout_stall", 16'(stall), 16'h0);
      access(1'b0, 16'h0090, 16'h0, 0, 16'h0, 1'b0, 1'b0);
      access(1'b1, 16'h0092, 16'h4444, 0, 16'h0, 1'b0, 1'b0);
      check("timeout_sticky_err", 16'(err), 16'h1);
      check("timeout_readData", readData, 16'h1111);

      // Misaligned load: no access, err next edge, later requests ignored.
      doReset();
      access(1'b0, 16'h0011, 16'h0, 0, 16'h0, 1'b0, 1'b0);
      check("misaligned_err", 16'(err), 16'h1);
      access(1'b0, 16'h0012, 16'h0, 0, 16'h0, 1'b0, 1'b0);
      check("misaligned_sticky", 16'(err), 16'h1);

      // MemRead and MemWrite together is illegal.
      doReset();
      MemRead = 1'b1; MemWrite = 1'b1; memAddr = 16'h0020;
      @(negedge clk);
      check("illegal_mem_start", 16'(mem_start), 16'h0);
      check("illegal_stall", 16'(stall), 16'h0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      check("illegal_err", 16'(err), 16'h1);

      // Halt with no request, then requests are blocked.
      doReset();
      HaltIn = 1'b1;
      @(posedge clk); #1;
      HaltIn = 1'b0;
      check("halt_idle", 16'(halt_out), 16'h1);
      check("halt_idle_err", 16'(err), 16'h0);
      access(1'b0, 16'h0010, 16'h0, 0, 16'h0, 1'b0, 1'b0);
      check("halt_sticky", 16'(halt_out), 16'h1);

      // Halt raised during RESP.
      doReset();
      access(1'b0, 16'h0100, 16'h0, 2, 16'h2468, 1'b1, 1'b1);
      check("halt_resp", 16'(halt_out), 16'h1);
      check("halt_resp_readData", readData, 16'h2468);

`ifdef DMEM_RDBUF_EN
      // Read buffer: repeated load hits, store to the address invalidates.
      doReset();
      access(1'b0, 16'h0040, 16'h0, 2, 16'hCAFE, 1'b1, 1'b0);
      access(1'b0, 16'h0040, 16'h0, 0, 16'h0, 1'b0, 1'b0);
      check("buf_hit_readData", readData, 16'hCAFE);
      access(1'b1, 16'h0040, 16'h7777, 1, 16'h0, 1'b1, 1'b0);
      access(1'b0, 16'h0040, 16'h0, 1, 16'h7777, 1'b1, 1'b0);
      check("buf_miss_readData", readData, 16'h7777);
`endif

      repeat (2) @(posedge clk); #1;
      check("exp_req_left", 16'(expReq.size()), 16'h0);
      check("exp_stall_left", 16'(expStall.size()), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
